uc_despacha_pedido: RTL and testbench

//  Read-side control unit for the elevator request RAM. The request-capture UC writes
//  (origem, destino) floor pairs into that RAM. This block pops each pair in FIFO order,

---
 rtl/uc_despacha_pedido_pkg.sv | 28 ++
 rtl/uc_despacha_pedido_if.sv | 36 +++
 rtl/uc_despacha_pedido_temporizador_porta.sv | 36 +++
 rtl/uc_despacha_pedido.sv | 140 ++++++++++++++
 tb/tb_uc_despacha_pedido.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uc_despacha_pedido_pkg.sv
// Shared definitions for the request-dispatch control unit.
// Holds the FSM state encoding, default bus widths, the door time, and the
// request RAM layout shared with the writer UC. A pair occupies two words:
// origem at an even address and destino at the following one.
package uc_despacha_pedido_pkg;

  localparam int ADDR_W_PADRAO  = 4;
  localparam int ANDAR_W_PADRAO = 4;
  localparam int T_PORTA_PADRAO = 50;

  // RAM layout: destino sits one word after its origem; a full pair is two words
  localparam int DESLOC_DESTINO = 1;
  localparam int PASSO_PEDIDO   = 2;

  typedef enum logic [3:0] {
    INICIAL         = 4'd0,
    OCIOSO          = 4'd1,
    LE_ORIGEM       = 4'd2,
    LE_DESTINO      = 4'd3,
    CAPTURA_DESTINO = 4'd4,
    VAI_ORIGEM      = 4'd5,
    PORTA_ORIGEM    = 4'd6,
    VAI_DESTINO     = 4'd7,
    PORTA_DESTINO   = 4'd8,
    FINALIZA        = 4'd9
  } estado_t;

endpackage

// File: rtl/uc_despacha_pedido_if.sv
// Bus between the dispatch UC and its neighbours: the read port of the
// request RAM plus the command/status lines of the motion datapath.
//   ram_addr      UC -> RAM     read address (synchronous RAM, data next cycle)
//   ram_dado      RAM -> UC     read data
//   andar_atual   motion -> UC  current elevator floor
//   chegou        motion -> UC  1-cycle pulse, elevator reached destino_cmd
//   destino_cmd   UC -> motion  commanded floor
//   mover         UC -> motion  move request
//   porta_aberta  UC -> motion  door-open indication
// master = the dispatch UC, slave = RAM/motion side.
interface uc_despacha_pedido_if
  import uc_despacha_pedido_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_PADRAO,
  parameter int ANDAR_W = ANDAR_W_PADRAO
);

  logic [ADDR_W-1:0]  ram_addr;
  logic [ANDAR_W-1:0] ram_dado;
  logic [ANDAR_W-1:0] andar_atual;
  logic               chegou;
  logic [ANDAR_W-1:0] destino_cmd;
  logic               mover;
  logic               porta_aberta;

  modport master (
    output ram_addr, destino_cmd, mover, porta_aberta,
    input  ram_dado, andar_atual, chegou
  );

  modport slave (
    input  ram_addr, destino_cmd, mover, porta_aberta,
    output ram_dado, andar_atual, chegou
  );

endinterface

// File: rtl/uc_despacha_pedido_temporizador_porta.sv
// Door timer. carregar (asserted on the cycle the FSM enters a door state)
// loads T_PORTA-1; while contar is high the count runs down and fim is raised
// on the last door cycle, so the door stays open for exactly T_PORTA cycles.
//   clock, reset  system clock / async active-high reset
//   carregar      load the door time
//   contar        FSM is in a door state
//   fim           last cycle of the door time
module uc_despacha_pedido_temporizador_porta
  import uc_despacha_pedido_pkg::*;
#(
  parameter int T_PORTA = T_PORTA_PADRAO
) (
  input  logic clock,
  input  logic reset,
  input  logic carregar,
  input  logic contar,
  output logic fim
);

  localparam int CNT_W = (T_PORTA > 1) ? $clog2(T_PORTA) : 1;

  logic [CNT_W-1:0] restante;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      restante <= '0;
    end else if (carregar) begin
      restante <= CNT_W'(T_PORTA - 1);
    end else if (contar && (restante != '0)) begin
      restante <= restante - CNT_W'(1);
    end
  end

  assign fim = contar && (restante == '0);

endmodule

// File: rtl/uc_despacha_pedido.sv
// Read-side control unit of the elevator request RAM. Pops (origem, destino)
// pairs in FIFO order, sends the elevator to origem, opens the door, sends it
// to destino, opens the door again, then counts the request as served.
//   clock, reset       system clock / async active-high reset
//   iniciar            level, leaves INICIAL
//   ptr_escrita        writer's next free address
//   bus                RAM read port + motion datapath (master side)
//   ocupado            high while serving a request
//   pedidos_atendidos  served requests, saturating at 255
module uc_despacha_pedido
  import uc_despacha_pedido_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_PADRAO,
  parameter int ANDAR_W = ANDAR_W_PADRAO,
  parameter int T_PORTA = T_PORTA_PADRAO
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  iniciar,
  input  logic [ADDR_W-1:0]     ptr_escrita,
  uc_despacha_pedido_if.master  bus,
  output logic                  ocupado,
  output logic [7:0]            pedidos_atendidos
);

  estado_t            estado, proximo;
  logic [ADDR_W-1:0]  rd_ptr;
  logic [ADDR_W-1:0]  pendentes;
  logic [ANDAR_W-1:0] origem, destino;
  logic               carregar, contar, fim;

  // Modular difference: pointer wrap needs no special handling. An odd
  // distance of 1 means the writer has not finished the pair yet.
  assign pendentes = ptr_escrita - rd_ptr;

  uc_despacha_pedido_temporizador_porta #(.T_PORTA(T_PORTA)) u_temporizador (
    .clock    (clock),
    .reset    (reset),
    .carregar (carregar),
    .contar   (contar),
    .fim      (fim)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) estado <= INICIAL;
    else       estado <= proximo;
  end

  // Next state and Moore outputs. The door timer is loaded on the transition
  // into a door state so its count lines up with the first open cycle.
  always_comb begin
    proximo          = estado;
    carregar         = 1'b0;
    contar           = 1'b0;
    bus.mover        = 1'b0;
    bus.porta_aberta = 1'b0;
    bus.ram_addr     = rd_ptr;
    ocupado          = 1'b1;
    case (estado)
      INICIAL: begin
        ocupado = 1'b0;
        if (iniciar) proximo = OCIOSO;
      end
      OCIOSO: begin
        ocupado = 1'b0;
        if (pendentes >= ADDR_W'(PASSO_PEDIDO)) proximo = LE_ORIGEM;
      end
      LE_ORIGEM: proximo = LE_DESTINO;
      LE_DESTINO: begin
        bus.ram_addr = rd_ptr + ADDR_W'(DESLOC_DESTINO);
        proximo      = CAPTURA_DESTINO;
      end
      CAPTURA_DESTINO: begin
        if (origem == bus.andar_atual) begin
          proximo  = PORTA_ORIGEM;
          carregar = 1'b1;
        end else begin
          proximo = VAI_ORIGEM;
        end
      end
      VAI_ORIGEM: begin
        bus.mover = 1'b1;
        if (bus.chegou) begin
          proximo  = PORTA_ORIGEM;
          carregar = 1'b1;
        end
      end
      PORTA_ORIGEM: begin
        bus.porta_aberta = 1'b1;
        contar           = 1'b1;
        if (fim) proximo = (destino == bus.andar_atual) ? FINALIZA : VAI_DESTINO;
      end
      VAI_DESTINO: begin
        bus.mover = 1'b1;
        if (bus.chegou) begin
          proximo  = PORTA_DESTINO;
          carregar = 1'b1;
        end
      end
      PORTA_DESTINO: begin
        bus.porta_aberta = 1'b1;
        contar           = 1'b1;
        if (fim) proximo = FINALIZA;
      end
      FINALIZA: proximo = OCIOSO;
      default:  proximo = INICIAL;
    endcase
  end

  // Request datapath: captures the pair from the synchronous RAM one cycle
  // after each address, loads the commanded floor just before each move,
  // and retires the pair in FINALIZA.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr            <= '0;
      origem            <= '0;
      destino           <= '0;
      bus.destino_cmd   <= '0;
      pedidos_atendidos <= '0;
    end else begin
      case (estado)
        INICIAL:    rd_ptr <= '0;
        LE_DESTINO: origem <= bus.ram_dado;
        CAPTURA_DESTINO: begin
          destino <= bus.ram_dado;
          if (origem != bus.andar_atual) bus.destino_cmd <= origem;
        end
        PORTA_ORIGEM: begin
          if (fim && (destino != bus.andar_atual)) bus.destino_cmd <= destino;
        end
        FINALIZA: begin
          rd_ptr <= rd_ptr + ADDR_W'(PASSO_PEDIDO);
          if (pedidos_atendidos != 8'hFF) pedidos_atendidos <= pedidos_atendidos + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uc_despacha_pedido.sv
// Directed bench for uc_despacha_pedido: a synchronous request RAM model,
// a hand-driven motion datapath (andar_atual/chegou) and hand-computed
// expectations for dispatch latency, door length, pointer wrap and reset.
module tb_uc_despacha_pedido;

  logic       clock;
  logic       reset;
  logic       iniciar;
  logic [3:0] ptr_escrita;
  logic       ocupado;
  logic [7:0] pedidos_atendidos;

  logic [3:0] mem [16];
  int checks = 0;
  int errors = 0;
  int overlap = 0;

  uc_despacha_pedido_if #(.ADDR_W(4), .ANDAR_W(4)) bus ();

  uc_despacha_pedido #(.ADDR_W(4), .ANDAR_W(4), .T_PORTA(50)) dut (
    .clock             (clock),
    .reset             (reset),
    .iniciar           (iniciar),
    .ptr_escrita       (ptr_escrita),
    .bus               (bus),
    .ocupado           (ocupado),
    .pedidos_atendidos (pedidos_atendidos)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // synchronous-read request RAM
  always @(posedge clock) bus.ram_dado <= mem[bus.ram_addr];

  // mover and porta_aberta must never be high together
  always @(negedge clock) if (bus.mover && bus.porta_aberta) overlap++;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic ini, input logic [3:0] ptr, input logic [3:0] andar);
    iniciar         = ini;
    ptr_escrita     = ptr;
    bus.andar_atual = andar;
  endtask

  task automatic pulseChegou(input logic [3:0] andar);
    bus.chegou      = 1'b1;
    bus.andar_atual = andar;
    tick();
    bus.chegou      = 1'b0;
  endtask

  // counts sampled cycles with the door open, starting at the current sample
  task automatic measureDoor(output int n);
    n = 0;
    while (bus.porta_aberta && n < 200) begin
      n++;
      tick();
    end
  endtask

  int  n;
  logic sawMover;

  initial begin
    reset = 1'b1;
    bus.chegou = 1'b0;
    applyStimulus(1'b0, 4'd0, 4'd0);
    for (int i = 0; i < 16; i++) mem[i] = 4'd0;
    repeat (2) tick();

    // reset state
    checkOutput("rst_mover", 32'(bus.mover), 0);
    checkOutput("rst_porta", 32'(bus.porta_aberta), 0);
    checkOutput("rst_ocupado", 32'(ocupado), 0);
    checkOutput("rst_ram_addr", 32'(bus.ram_addr), 0);
    checkOutput("rst_destino_cmd", 32'(bus.destino_cmd), 0);
    checkOutput("rst_pedidos", 32'(pedidos_atendidos), 0);
    reset = 1'b0;

    // 1: start with an empty RAM, nothing dispatched
    applyStimulus(1'b1, 4'd0, 4'd0);
    repeat (4) tick();
    checkOutput("t1_ocupado", 32'(ocupado), 0);
    checkOutput("t1_ram_addr", 32'(bus.ram_addr), 0);

    // 2: request 3 -> 7 from floor 0
    mem[0] = 4'd3;
    mem[1] = 4'd7;
    applyStimulus(1'b1, 4'd2, 4'd0);
    tick();
    checkOutput("t2_ocupado_le_origem", 32'(ocupado), 1);
    checkOutput("t2_addr_origem", 32'(bus.ram_addr), 0);
    tick();
    checkOutput("t2_addr_destino", 32'(bus.ram_addr), 1);
    tick();
    checkOutput("t2_mover_early", 32'(bus.mover), 0);
    tick();
    checkOutput("t2_mover_latency", 32'(bus.mover), 1);
    checkOutput("t2_cmd_origem", 32'(bus.destino_cmd), 3);
    repeat (3) tick();
    checkOutput("t2_mover_hold", 32'(bus.mover), 1);
    pulseChegou(4'd3);
    checkOutput("t2_porta_origem_on", 32'(bus.porta_aberta), 1);
    checkOutput("t2_mover_off", 32'(bus.mover), 0);
    measureDoor(n);
    checkOutput("t2_porta_origem_len", 32'(n), 50);
    checkOutput("t2_mover_destino", 32'(bus.mover), 1);
    checkOutput("t2_cmd_destino", 32'(bus.destino_cmd), 7);
    pulseChegou(4'd7);
    checkOutput("t2_porta_destino_on", 32'(bus.porta_aberta), 1);
    measureDoor(n);
    checkOutput("t2_porta_destino_len", 32'(n), 50);
    checkOutput("t2_finaliza_ocupado", 32'(ocupado), 1);
    tick();
    checkOutput("t2_pedidos", 32'(pedidos_atendidos), 1);
    checkOutput("t2_rd_ptr", 32'(bus.ram_addr), 2);
    checkOutput("t2_idle", 32'(ocupado), 0);

    // 3: origem equals current floor -> door first, then one move
    mem[2] = 4'd5;
    mem[3] = 4'd2;
    applyStimulus(1'b0, 4'd4, 4'd5);
    sawMover = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.mover) sawMover = 1'b1;
    end
    checkOutput("t3_no_first_move", 32'(sawMover), 0);
    checkOutput("t3_porta_now", 32'(bus.porta_aberta), 1);
    measureDoor(n);
    checkOutput("t3_porta_len", 32'(n), 50);
    checkOutput("t3_mover", 32'(bus.mover), 1);
    checkOutput("t3_cmd", 32'(bus.destino_cmd), 2);
    pulseChegou(4'd2);
    measureDoor(n);
    checkOutput("t3_porta_dest_len", 32'(n), 50);
    tick();
    checkOutput("t3_pedidos", 32'(pedidos_atendidos), 2);
    checkOutput("t3_rd_ptr", 32'(bus.ram_addr), 4);

    // 4: incomplete pair is held back until its destino is written
    mem[4] = 4'd2;
    mem[5] = 4'd2;
    applyStimulus(1'b0, 4'd5, 4'd2);
    repeat (5) tick();
    checkOutput("t4_odd_no_dispatch", 32'(ocupado), 0);
    ptr_escrita = 4'd6;
    tick();
    checkOutput("t4_dispatch_1cyc", 32'(ocupado), 1);
    checkOutput("t4_addr", 32'(bus.ram_addr), 4);
    sawMover = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.mover) sawMover = 1'b1;
    end
    checkOutput("t4_porta_now", 32'(bus.porta_aberta), 1);
    measureDoor(n);
    checkOutput("t4_porta_len", 32'(n), 50);
    checkOutput("t4_no_move", 32'(sawMover | bus.mover), 0);
    checkOutput("t4_finaliza", 32'(ocupado), 1);
    tick();
    checkOutput("t4_pedidos", 32'(pedidos_atendidos), 3);
    checkOutput("t4_rd_ptr", 32'(bus.ram_addr), 6);

    // 5: four back-to-back local requests bring rd_ptr to 14, then one wraps
    for (int i = 6; i < 14; i++) mem[i] = 4'd2;
    ptr_escrita = 4'd14;
    n = 0;
    sawMover = 1'b0;
    tick();
    while (!(pedidos_atendidos == 8'd7 && !ocupado) && n < 1000) begin
      if (bus.mover) sawMover = 1'b1;
      n++;
      tick();
    end
    checkOutput("t5_pedidos_7", 32'(pedidos_atendidos), 7);
    checkOutput("t5_rd_ptr_14", 32'(bus.ram_addr), 14);
    checkOutput("t5_local_no_move", 32'(sawMover), 0);
    mem[14] = 4'd9;
    mem[15] = 4'd4;
    ptr_escrita = 4'd0;
    tick();
    checkOutput("t5_addr_14", 32'(bus.ram_addr), 14);
    tick();
    checkOutput("t5_addr_15", 32'(bus.ram_addr), 15);
    repeat (2) tick();
    checkOutput("t5_cmd_origem", 32'(bus.destino_cmd), 9);
    pulseChegou(4'd9);
    measureDoor(n);
    checkOutput("t5_porta_len", 32'(n), 50);
    checkOutput("t5_cmd_destino", 32'(bus.destino_cmd), 4);
    pulseChegou(4'd4);
    measureDoor(n);
    tick();
    checkOutput("t5_pedidos_8", 32'(pedidos_atendidos), 8);
    checkOutput("t5_wrap_rd_ptr", 32'(bus.ram_addr), 0);
    repeat (3) tick();
    checkOutput("t5_idle", 32'(ocupado), 0);

    // 6: reset while travelling to destino
    mem[0] = 4'd1;
    mem[1] = 4'd3;
    applyStimulus(1'b0, 4'd2, 4'd4);
    repeat (4) tick();
    checkOutput("t6_cmd_origem", 32'(bus.destino_cmd), 1);
    pulseChegou(4'd1);
    measureDoor(n);
    checkOutput("t6_mover_destino", 32'(bus.mover), 1);
    reset = 1'b1;
    #1;
    checkOutput("t6_rst_mover", 32'(bus.mover), 0);
    checkOutput("t6_rst_porta", 32'(bus.porta_aberta), 0);
    checkOutput("t6_rst_ocupado", 32'(ocupado), 0);
    checkOutput("t6_rst_pedidos", 32'(pedidos_atendidos), 0);
    checkOutput("t6_rst_cmd", 32'(bus.destino_cmd), 0);
    checkOutput("t6_rst_addr", 32'(bus.ram_addr), 0);
    tick();
    reset = 1'b0;
    repeat (3) tick();
    checkOutput("t6_inicial_holds", 32'(ocupado), 0);
    iniciar = 1'b1;
    repeat (2) tick();
    checkOutput("t6_restart_dispatch", 32'(ocupado), 1);
    checkOutput("t6_restart_addr", 32'(bus.ram_addr), 0);

    checkOutput("no_mover_porta_overlap", 32'(overlap), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
